// File: rtl/spi_param_ctrl.sv
// Turns SPI frames into parameter-bank writes and commit pulses. The path runs edge detect -> FIFO -> write FSM.
// An event in cycle N gives par_we=1 from N+2. A write is held until ack or timeout, and a frame that arrives while the FIFO is full is dropped and flagged.
module spi_param_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_adrs,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [6:0] par_adrs,
    output logic [7:0] par_data,
    output logic       par_we,
    input  logic       par_ack,
    output logic       commit,
    output logic       overflow,
    output logic       ack_err,
    input  logic       clear_err,
    output logic       busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(ACK_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    typedef struct packed {
        logic       is_commit;
        logic [6:0] adrs;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_COMMIT} state_t;

    state_t           state_q, state_d;
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rx_valid_d_q, rx_valid_d_d;
    logic [6:0]       par_adrs_q, par_adrs_d;
    logic [7:0]       par_data_q, par_data_d;
    logic             par_we_q, par_we_d;
    logic             commit_q, commit_d;
    logic             overflow_q, overflow_d;
    logic             ack_err_q, ack_err_d;

    logic   frame_evt, push_req, push, pop, full, ovf_set, ack_set;
    entry_t head;

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        tmo_d        = tmo_q;
        rx_valid_d_d = rx_valid;
        par_adrs_d   = par_adrs_q;
        par_data_d   = par_data_q;
        par_we_d     = par_we_q;
        commit_d     = commit_q;
        ack_set      = 1'b0;

        // 0x80..0xFE are neither writes nor commits and vanish here
        frame_evt = rx_valid & ~rx_valid_d_q;
        push_req  = frame_evt & (~rx_adrs[7] | (rx_adrs == 8'hFF));
        full      = (count_q == FULL_CNT);
        push      = push_req & ~full;
        ovf_set   = push_req & full;
        pop       = (state_q == ST_IDLE) && (count_q != '0);
        head      = mem_q[rd_ptr_q];

        if (push) begin
            mem_d[wr_ptr_q] = '{is_commit: rx_adrs[7], adrs: rx_adrs[6:0], data: rx_data};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    if (head.is_commit) begin
                        commit_d = 1'b1;
                        state_d  = ST_COMMIT;
                    end else begin
                        par_adrs_d = head.adrs;
                        par_data_d = head.data;
                        par_we_d   = 1'b1;
                        tmo_d      = '0;
                        state_d    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (par_ack) begin
                    par_we_d = 1'b0;
                    tmo_d    = '0;
                    state_d  = ST_IDLE;
                end else if (tmo_q + TMO_ONE == TMO_LIM) begin
                    par_we_d = 1'b0;
                    ack_set  = 1'b1;
                    tmo_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            ST_COMMIT: begin
                commit_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // a set in the same cycle as clear_err takes priority
        overflow_d = (overflow_q & ~clear_err) | ovf_set;
        ack_err_d  = (ack_err_q & ~clear_err) | ack_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tmo_q        <= '0;
            rx_valid_d_q <= 1'b0;
            par_adrs_q   <= '0;
            par_data_q   <= '0;
            par_we_q     <= 1'b0;
            commit_q     <= 1'b0;
            overflow_q   <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tmo_q        <= tmo_d;
            rx_valid_d_q <= rx_valid_d_d;
            par_adrs_q   <= par_adrs_d;
            par_data_q   <= par_data_d;
            par_we_q     <= par_we_d;
            commit_q     <= commit_d;
            overflow_q   <= overflow_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign par_adrs = par_adrs_q;
    assign par_data = par_data_q;
    assign par_we   = par_we_q;
    assign commit   = commit_q;
    assign overflow = overflow_q;
    assign ack_err  = ack_err_q;
    assign busy     = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_param_ctrl.sv
// Bench for spi_param_ctrl: frames feed an ordered queue of expected bus operations.
// A negedge monitor pops that queue whenever a write starts or a commit pulses, and it also answers par_ack.
module tb_spi_param_ctrl;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_adrs = '0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [6:0] par_adrs;
    logic [7:0] par_data;
    logic       par_we;
    logic       par_ack = 1'b0;
    logic       commit;
    logic       overflow;
    logic       ack_err;
    logic       clear_err = 1'b0;
    logic       busy;

    always #5 clk = ~clk;

    spi_param_ctrl #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_adrs(rx_adrs), .rx_data(rx_data), .rx_valid(rx_valid),
        .par_adrs(par_adrs), .par_data(par_data), .par_we(par_we), .par_ack(par_ack),
        .commit(commit), .overflow(overflow), .ack_err(ack_err),
        .clear_err(clear_err), .busy(busy)
    );

    typedef struct {
        bit       is_commit;
        bit [6:0] adrs;
        bit [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0, n_err = 0;
    int   writes_seen = 0, commits_seen = 0, we_falls = 0;
    int   we_run = 0, last_we_len = 0, cyc = 0, fall_cyc = 0, commit_cyc = 0;
    bit   we_prev = 0, commit_prev = 0;
    bit   ack_auto = 1;
    int   ack_delay = 1;
    int   ack_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input string msg);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s (t=%0t)", name, msg, $time);
    endtask

    // Reference decode: what the bus should eventually show for one frame
    task automatic model_frame(input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        if (!a[7]) begin
            e.is_commit = 0; e.adrs = a[6:0]; e.data = d;
            exp_q.push_back(e);
        end else if (a == 8'hFF) begin
            e.is_commit = 1; e.adrs = '0; e.data = '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_frame(input logic [7:0] a, input logic [7:0] d, input int len);
        rx_adrs  = a;
        rx_data  = d;
        rx_valid = 1'b1;
        repeat (len) @(posedge clk);
        #1 rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input int len);
        model_frame(a, d);
        drive_frame(a, d, len);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i = 0;
        while ((busy || exp_q.size() != 0) && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (busy || exp_q.size() != 0)
            flag(name, $sformatf("not idle after %0d cycles, %0d ops outstanding", budget, exp_q.size()));
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
    endtask

    // Monitor and ack responder
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            we_prev = 0; commit_prev = 0; we_run = 0;
            par_ack = 1'b0; ack_cnt = 0;
        end else begin
            if (par_we && !we_prev) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    flag("unexpected_write", $sformatf("adrs 0x%0h data 0x%0h", par_adrs, par_data));
                end else begin
                    e = exp_q.pop_front();
                    chk("op_is_write", 32'(e.is_commit), 32'(0));
                    chk("write_adrs", 32'(par_adrs), 32'(e.adrs));
                    chk("write_data", 32'(par_data), 32'(e.data));
                end
            end
            if (par_we) begin
                we_run++;
            end else if (we_prev) begin
                last_we_len = we_run;
                we_run      = 0;
                we_falls++;
                fall_cyc    = cyc;
            end
            if (commit) begin
                commits_seen++;
                commit_cyc = cyc;
                chk("commit_one_cycle", 32'(commit_prev), 32'(0));
                chk("commit_while_we", 32'(par_we), 32'(0));
                if (exp_q.size() == 0) begin
                    flag("unexpected_commit", "no commit outstanding");
                end else begin
                    e = exp_q.pop_front();
                    chk("op_is_commit", 32'(e.is_commit), 32'(1));
                end
            end
            we_prev     = par_we;
            commit_prev = commit;
            if (ack_auto && par_we) begin
                if (ack_cnt >= ack_delay) begin
                    par_ack = 1'b1;
                    ack_cnt = 0;
                end else begin
                    par_ack = 1'b0;
                    ack_cnt++;
                end
            end else begin
                par_ack = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, c0, r, nb;
        logic [7:0] a, d;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_par_we", 32'(par_we), 32'(0));
        chk("rst_commit", 32'(commit), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_ack_err", 32'(ack_err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_par_adrs", 32'(par_adrs), 32'(0));
        chk("rst_par_data", 32'(par_data), 32'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Long rx_valid, one write, latency from rx_valid rise
        ack_auto = 1; ack_delay = 1;
        w0 = writes_seen;
        model_frame(8'h12, 8'hA5);
        rx_adrs = 8'h12; rx_data = 8'hA5; rx_valid = 1'b1;
        @(posedge clk); #1;
        chk("lat_we_n1", 32'(par_we), 32'(0));
        @(posedge clk); #1;
        chk("lat_we_n2", 32'(par_we), 32'(1));
        repeat (8) @(posedge clk);
        #1 rx_valid = 1'b0;
        wait_idle(50, "t1_idle");
        chk("t1_write_count", 32'(writes_seen - w0), 32'(1));

        // Write then commit with slow ack
        ack_delay = 5;
        c0 = commits_seen;
        send_frame(8'h05, 8'h33, 1);
        send_frame(8'hFF, 8'h77, 1);
        wait_idle(60, "t2_idle");
        chk("t2_commit_count", 32'(commits_seen - c0), 32'(1));
        chk("t2_commit_gap", 32'(commit_cyc - fall_cyc), 32'(1));

        // Overflow: ack held off, sixth frame dropped
        ack_auto = 0;
        w0 = writes_seen;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) model_frame(8'(8'h40 + i), 8'(8'hC0 + i));
            drive_frame(8'(8'h40 + i), 8'(8'hC0 + i), 1);
        end
        chk("t3_overflow_set", 32'(overflow), 32'(1));
        chk("t3_busy", 32'(busy), 32'(1));
        pulse_clear();
        chk("t3_overflow_clr", 32'(overflow), 32'(0));
        wait_idle(300, "t3_idle");
        chk("t3_write_count", 32'(writes_seen - w0), 32'(5));
        chk("t3_ack_err", 32'(ack_err), 32'(1));
        pulse_clear();

        // Timeout then next write issued
        chk("t4_ack_err_pre", 32'(ack_err), 32'(0));
        w0 = writes_seen;
        c0 = we_falls;
        send_frame(8'h21, 8'h44, 1);
        send_frame(8'h22, 8'h55, 1);
        for (int i = 0; i < 100 && we_falls == c0; i++) begin
            @(posedge clk); #1;
        end
        if (we_falls == c0) flag("t4_first_timeout", "par_we never dropped");
        chk("t4_we_len_1", 32'(last_we_len), 32'(TMO));
        chk("t4_ack_err", 32'(ack_err), 32'(1));
        wait_idle(100, "t4_idle");
        chk("t4_write_count", 32'(writes_seen - w0), 32'(2));
        chk("t4_we_len_2", 32'(last_we_len), 32'(TMO));
        pulse_clear();
        chk("t4_ack_err_clr", 32'(ack_err), 32'(0));

        // Discarded addresses
        ack_auto = 1; ack_delay = 0;
        w0 = writes_seen; c0 = commits_seen;
        send_frame(8'h80, 8'h11, 2);
        chk("t5_busy_80", 32'(busy), 32'(0));
        send_frame(8'hFE, 8'h22, 1);
        chk("t5_busy_fe", 32'(busy), 32'(0));
        repeat (4) begin @(posedge clk); #1; end
        chk("t5_no_write", 32'(writes_seen - w0), 32'(0));
        chk("t5_no_commit", 32'(commits_seen - c0), 32'(0));

        // Randomised bursts against the ordered model
        for (int it = 0; it < 30; it++) begin
            ack_delay = $urandom_range(0, 6);
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                r = $urandom_range(0, 3);
                case (r)
                    0, 1:    a = {1'b0, 7'($urandom)};
                    2:       a = 8'hFF;
                    default: a = 8'($urandom_range(128, 254));
                endcase
                d = 8'($urandom);
                send_frame(a, d, $urandom_range(1, 3));
            end
            wait_idle(200, "rand_idle");
        end
        chk("rand_overflow", 32'(overflow), 32'(0));
        chk("rand_ack_err", 32'(ack_err), 32'(0));

        // Reset in the middle of a write with entries queued
        ack_auto = 0;
        send_frame(8'h31, 8'h01, 1);
        send_frame(8'h32, 8'h02, 1);
        send_frame(8'h33, 8'h03, 1);
        chk("t6_we_before", 32'(par_we), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("t6_we_rst", 32'(par_we), 32'(0));
        chk("t6_commit_rst", 32'(commit), 32'(0));
        chk("t6_busy_rst", 32'(busy), 32'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        ack_auto = 1;
        w0 = writes_seen;
        repeat (20) begin @(posedge clk); #1; end
        chk("t6_no_writes", 32'(writes_seen - w0), 32'(0));
        chk("t6_busy_after", 32'(busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
